// File: rtl/median_window_ctrl_pkg.sv
// Shared types and constants for the 3x3 binary median window sequencer.
// A window column is packed as [0]=top, [1]=mid, [2]=bottom.
package median_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int WIN_DIM  = 3;
  localparam int WIN_BITS = 9;
  localparam int CENTRE   = 4;
  localparam int NEWEST   = 8;

  typedef logic [WIN_DIM-1:0] col_t;

  // window[3*i+j]: i = row from the top, j = column from the left (oldest)
  function automatic logic [WIN_BITS-1:0] pack_window(input col_t left,
                                                       input col_t mid,
                                                       input col_t right);
    logic [WIN_BITS-1:0] w;
    w = '0;
    for (int i = 0; i < WIN_DIM; i++) begin
      w[WIN_DIM*i + 0] = left[i];
      w[WIN_DIM*i + 1] = mid[i];
      w[WIN_DIM*i + 2] = right[i];
    end
    return w;
  endfunction

endpackage

// File: rtl/line_buf_sr.sv
// One image line of delay: q is the pixel accepted DEPTH enables ago.
module line_buf_sr #(
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] sr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr <= '0;
    end else if (en) begin
      sr <= {sr[DEPTH-2:0], d};
    end
  end

  assign q = sr[DEPTH-1];

endmodule

// File: rtl/median_window_ctrl.sv
// Frame sequencer: buffers two lines of a raster 1-bit stream and issues one
// registered 3x3 window per interior pixel with valid/ready flow control.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | accepting pixels, issuing windows
// DRAIN | last pixel taken, waiting for the final window to retire
// DONE  | one-cycle frame_done pulse
module median_window_ctrl
  import median_pkg::*;
#(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int CW    = $clog2(IMG_W),
  parameter int RW    = $clog2(IMG_H)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                pix_in,
  input  logic                pix_valid,
  output logic                pix_ready,
  output logic [WIN_BITS-1:0] window_out,
  output logic                win_valid,
  input  logic                win_ready,
  output logic [RW-1:0]       out_row,
  output logic [CW-1:0]       out_col,
  output logic                busy,
  output logic                frame_done
);

  state_t        state, state_nx;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          lb1_q, lb0_q;
  col_t          hist_old, hist_new, new_col;
  logic          accept, issue, last_pix;

  assign accept   = pix_valid & pix_ready;
  assign last_pix = (row == RW'(IMG_H-1)) && (col == CW'(IMG_W-1));
  // c>=2 keeps windows from straddling a row wrap
  assign issue    = accept && (row >= RW'(2)) && (col >= CW'(2));
  assign new_col  = {pix_in, lb1_q, lb0_q};

  line_buf_sr #(.DEPTH(IMG_W)) u_lb1 (
    .clk   (clk),
    .reset (reset),
    .en    (accept),
    .d     (pix_in),
    .q     (lb1_q)
  );

  line_buf_sr #(.DEPTH(IMG_W)) u_lb0 (
    .clk   (clk),
    .reset (reset),
    .en    (accept),
    .d     (lb1_q),
    .q     (lb0_q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    busy       = 1'b0;
    frame_done = 1'b0;
    pix_ready  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nx = ST_RUN;
      end
      ST_RUN: begin
        busy      = 1'b1;
        pix_ready = ~win_valid | win_ready;
        if (pix_valid && pix_ready && last_pix) state_nx = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (!win_valid || win_ready) state_nx = ST_DONE;
      end
      ST_DONE: begin
        frame_done = 1'b1;
        state_nx   = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if (state == ST_IDLE && start) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col == CW'(IMG_W-1)) begin
        col <= '0;
        row <= row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // The two most recent columns; the third comes straight from the taps/pix_in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_old <= '0;
      hist_new <= '0;
    end else if (accept) begin
      hist_old <= hist_new;
      hist_new <= new_col;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      window_out <= '0;
      out_row    <= '0;
      out_col    <= '0;
      win_valid  <= 1'b0;
    end else if (issue) begin
      window_out <= pack_window(hist_old, hist_new, new_col);
      out_row    <= row - RW'(1);
      out_col    <= col - CW'(1);
      win_valid  <= 1'b1;
    end else if (win_ready) begin
      win_valid  <= 1'b0;
    end
  end

endmodule
